// File: rtl/video_acc_pkg.sv
// Shared constants and bank-state type for the video accelerator blocks.
package video_acc_pkg;

    localparam int unsigned BLK_DIM = 8;
    localparam int unsigned PIX_W   = 8;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

endpackage

// File: rtl/stream_transpose8_bank.sv
// One 8x8 byte array: whole-row write port, whole-column combinational read port.
module transpose_bank
    import video_acc_pkg::*;
(
    input  logic                     aclk,
    input  logic                     we,
    input  logic                     zfill,
    input  logic [2:0]               wr_row,
    input  logic [BLK_DIM*PIX_W-1:0] wr_data,
    input  logic [2:0]               rd_col,
    output logic [BLK_DIM*PIX_W-1:0] rd_data
);

    logic [BLK_DIM*PIX_W-1:0] rows [BLK_DIM];

    // A short-packet close writes its row and clears every row below it in the same cycle.
    always_ff @(posedge aclk) begin
        if (we) begin
            for (int unsigned r = 0; r < BLK_DIM; r++) begin
                if (3'(r) == wr_row)
                    rows[r] <= wr_data;
                else if (zfill && (3'(r) > wr_row))
                    rows[r] <= '0;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned r = 0; r < BLK_DIM; r++)
            rd_data[r*PIX_W +: PIX_W] = rows[r][{rd_col, 3'b000} +: PIX_W];
    end

endmodule

// File: rtl/stream_transpose8.sv
// AXI-stream 8x8 byte-block transposer with ping-pong banks.
module stream_transpose8
    import video_acc_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 3,
    parameter int OUT_DEST   = 0
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  src_tvalid,
    output logic                  src_tready,
    input  logic                  src_tlast,
    input  logic [DATA_WIDTH-1:0] src_tdata,
    input  logic [DEST_WIDTH-1:0] src_tdest,
    output logic                  dest_tvalid,
    input  logic                  dest_tready,
    output logic                  dest_tlast,
    output logic [DATA_WIDTH-1:0] dest_tdata,
    output logic [DEST_WIDTH-1:0] dest_tdest,
    input  logic                  clr_err,
    output logic                  err_short,
    output logic [15:0]           blk_cnt,
    output logic                  busy
);

    bank_state_t     st [2];
    logic [1:0]      blk_last;
    logic            wr_sel;
    logic            rd_sel;
    logic [2:0]      wr_row;
    logic [2:0]      rd_col;

    logic            src_hs;
    logic            wr_close;
    logic            short_ev;
    logic            dest_hs;
    logic            drain_done;
    logic [DATA_WIDTH-1:0] bank_rd0;
    logic [DATA_WIDTH-1:0] bank_rd1;
    logic            unused_ok;

    assign unused_ok = ^src_tdest;

    assign src_tready  = (st[wr_sel] == BANK_EMPTY) || (st[wr_sel] == BANK_FILLING);
    assign src_hs      = src_tvalid && src_tready;
    assign wr_close    = src_hs && ((wr_row == 3'd7) || src_tlast);
    assign short_ev    = src_hs && src_tlast && (wr_row != 3'd7);

    assign dest_tvalid = (st[rd_sel] == BANK_FULL) || (st[rd_sel] == BANK_DRAINING);
    assign dest_hs     = dest_tvalid && dest_tready;
    assign drain_done  = dest_hs && (rd_col == 3'd7);
    assign dest_tlast  = dest_tvalid && (rd_col == 3'd7) && blk_last[rd_sel];
    assign dest_tdata  = rd_sel ? bank_rd1 : bank_rd0;
    assign dest_tdest  = DEST_WIDTH'(OUT_DEST);

    assign busy = (st[0] != BANK_EMPTY) || (st[1] != BANK_EMPTY);

    // Write and read sides never act on the same bank in one cycle (their state sets are disjoint),
    // so a close on one bank and a drain finish on the other both land.
    always_ff @(posedge aclk) begin
        if (areset) begin
            st[0]     <= BANK_EMPTY;
            st[1]     <= BANK_EMPTY;
            blk_last  <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_row    <= '0;
            rd_col    <= '0;
            blk_cnt   <= '0;
            err_short <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (src_hs && (wr_sel == 1'(i))) begin
                    st[i] <= wr_close ? BANK_FULL : BANK_FILLING;
                    if (wr_close)
                        blk_last[i] <= src_tlast;
                end else if (dest_hs && (rd_sel == 1'(i))) begin
                    st[i] <= drain_done ? BANK_EMPTY : BANK_DRAINING;
                end
            end

            if (src_hs) begin
                wr_row <= wr_close ? 3'd0 : wr_row + 3'd1;
                if (wr_close)
                    wr_sel <= ~wr_sel;
            end

            if (dest_hs) begin
                rd_col <= rd_col + 3'd1;
                if (drain_done) begin
                    rd_sel  <= ~rd_sel;
                    blk_cnt <= blk_cnt + 16'd1;
                end
            end

            if (short_ev)
                err_short <= 1'b1;
            else if (clr_err)
                err_short <= 1'b0;
        end
    end

    transpose_bank u_bank0 (
        .aclk    (aclk),
        .we      (src_hs && !wr_sel),
        .zfill   (short_ev),
        .wr_row  (wr_row),
        .wr_data (src_tdata),
        .rd_col  (rd_col),
        .rd_data (bank_rd0)
    );

    transpose_bank u_bank1 (
        .aclk    (aclk),
        .we      (src_hs && wr_sel),
        .zfill   (short_ev),
        .wr_row  (wr_row),
        .wr_data (src_tdata),
        .rd_col  (rd_col),
        .rd_data (bank_rd1)
    );

endmodule

// File: tb/tb_stream_transpose8.sv
// Scoreboard bench for stream_transpose8: directed scenarios plus randomized valid/ready traffic.
module tb_stream_transpose8;

    logic        aclk = 1'b0;
    logic        areset;
    logic        src_tvalid;
    logic        src_tready;
    logic        src_tlast;
    logic [63:0] src_tdata;
    logic [2:0]  src_tdest;
    logic        dest_tvalid;
    logic        dest_tready;
    logic        dest_tlast;
    logic [63:0] dest_tdata;
    logic [2:0]  dest_tdest;
    logic        clr_err;
    logic        err_short;
    logic [15:0] blk_cnt;
    logic        busy;

    always #5 aclk = ~aclk;

    stream_transpose8 #(.DATA_WIDTH(64), .DEST_WIDTH(3), .OUT_DEST(0)) dut (
        .aclk        (aclk),
        .areset      (areset),
        .src_tvalid  (src_tvalid),
        .src_tready  (src_tready),
        .src_tlast   (src_tlast),
        .src_tdata   (src_tdata),
        .src_tdest   (src_tdest),
        .dest_tvalid (dest_tvalid),
        .dest_tready (dest_tready),
        .dest_tlast  (dest_tlast),
        .dest_tdata  (dest_tdata),
        .dest_tdest  (dest_tdest),
        .clr_err     (clr_err),
        .err_short   (err_short),
        .blk_cnt     (blk_cnt),
        .busy        (busy)
    );

    localparam int LIMIT = 6000;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned hs_cyc = 0;
    int          in_cnt = 0;
    logic [64:0] exp_q [$];
    int unsigned out_cyc [$];
    logic [63:0] out_data [$];
    bit          rnd_ready = 0;
    bit          fixed_ready = 0;
    bit          drv_done;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Ready generator: fixed level or coin flip, updated after the driver's post-edge slot.
    initial begin
        dest_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #2;
            dest_tready = rnd_ready ? 1'($urandom % 2) : fixed_ready;
        end
    end

    // Monitor: compares every output handshake against the head of the expected queue.
    initial begin
        logic        stall_prev;
        logic [63:0] stall_data;
        logic        stall_last;
        logic [64:0] e;
        stall_prev = 1'b0;
        stall_data = '0;
        stall_last = 1'b0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", 64'(dest_tvalid), 64'd1);
                    check("hold_data", dest_tdata, stall_data);
                    check("hold_last", 64'(dest_tlast), 64'(stall_last));
                end
                if (dest_tvalid && dest_tready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_beat: got %h with nothing expected", dest_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", dest_tdata, e[63:0]);
                        check("beat_last", 64'(dest_tlast), 64'(e[64]));
                        check("beat_dest", 64'(dest_tdest), 64'd0);
                    end
                    out_cyc.push_back(cyc);
                    out_data.push_back(dest_tdata);
                end
                stall_prev = dest_tvalid && !dest_tready;
                stall_data = dest_tdata;
                stall_last = dest_tlast;
            end
        end
    end

    // Sends one packet of n rows (n<8 only with tlast) and queues the transposed block it should yield.
    task automatic send_block(input int n, input bit last, input int gap_max, input bit pattern);
        logic [63:0] rows [8];
        logic [63:0] beat;
        int          w;
        for (int r = 0; r < 8; r++) begin
            if (pattern)
                for (int c = 0; c < 8; c++) rows[r][8*c +: 8] = 8'(8*r + c);
            else
                rows[r] = {$urandom, $urandom};
        end
        for (int c = 0; c < 8; c++) begin
            beat = '0;
            for (int r = 0; r < n; r++) beat[8*r +: 8] = rows[r][8*c +: 8];
            exp_q.push_back({(c == 7) && last, beat});
        end
        for (int r = 0; r < n; r++) begin
            repeat ($urandom_range(0, gap_max)) begin
                src_tvalid = 1'b0;
                @(posedge aclk);
                #1;
            end
            src_tvalid = 1'b1;
            src_tdata  = rows[r];
            src_tdest  = 3'($urandom);
            src_tlast  = (r == n - 1) && last;
            w = 0;
            @(negedge aclk);
            while (!src_tready && w < LIMIT) begin
                @(negedge aclk);
                w++;
            end
            if (w >= LIMIT) begin
                tests++;
                fails++;
                $display("FAIL src_timeout: src_tready stayed 0 for %0d cycles", w);
            end
            @(posedge aclk);
            #1;
            in_cnt++;
            hs_cyc = cyc;
        end
        src_tvalid = 1'b0;
        src_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < LIMIT) begin
            @(posedge aclk);
            w++;
        end
        tests++;
        if (w >= LIMIT) begin
            fails++;
            $display("FAIL drain_timeout: %0d beats still pending", exp_q.size());
        end
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int          first_hs;
        int          n;
        bit          last;
        int          w;
        logic [63:0] b;

        areset     = 1'b1;
        src_tvalid = 1'b0;
        src_tlast  = 1'b0;
        src_tdata  = '0;
        src_tdest  = '0;
        clr_err    = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        check("rst_valid", 64'(dest_tvalid), 64'd0);
        check("rst_last", 64'(dest_tlast), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        check("post_rst_ready", 64'(src_tready), 64'd1);
        check("post_rst_blk_cnt", 64'(blk_cnt), 64'd0);
        check("post_rst_err", 64'(err_short), 64'd0);
        check("post_rst_valid", 64'(dest_tvalid), 64'd0);

        // Single patterned block
        fixed_ready = 1;
        out_data.delete();
        send_block(8, 1, 0, 1);
        wait_drain();
        check("single_beats", 64'(out_data.size()), 64'd8);
        if (out_data.size() >= 8) begin
            check("single_beat0", out_data[0], 64'h3830282018100800);
            check("single_beat7", out_data[7], 64'h3F372F271F170F07);
        end
        check("single_blk_cnt", 64'(blk_cnt), 64'd1);

        // Four back-to-back blocks
        out_cyc.delete();
        send_block(8, 1'($urandom % 2), 0, 0);
        first_hs = int'(hs_cyc);
        repeat (3) send_block(8, 1'($urandom % 2), 0, 0);
        wait_drain();
        check("stream_beats", 64'(out_cyc.size()), 64'd32);
        if (out_cyc.size() == 32) begin
            check("stream_latency", 64'(out_cyc[0]), 64'(first_hs));
            check("stream_no_gaps", 64'(out_cyc[31] - out_cyc[0]), 64'd31);
        end

        // Backpressure: three blocks against a stalled sink
        fixed_ready = 0;
        @(posedge aclk);
        #1;
        in_cnt = 0;
        out_cyc.delete();
        drv_done = 0;
        fork
            begin
                repeat (3) send_block(8, 1, 0, 0);
                drv_done = 1;
            end
        join_none
        repeat (40) @(posedge aclk);
        #1;
        check("bp_accepted", 64'(in_cnt), 64'd16);
        check("bp_src_ready", 64'(src_tready), 64'd0);
        fixed_ready = 1;
        w = 0;
        while (!drv_done && w < LIMIT) begin
            @(posedge aclk);
            w++;
        end
        check("bp_driver_done", 64'(drv_done), 64'd1);
        wait_drain();
        check("bp_beats", 64'(out_cyc.size()), 64'd24);
        check("bp_blk_cnt", 64'(blk_cnt), 64'd8);

        // Short packet: three rows then tlast
        out_data.delete();
        send_block(3, 1, 0, 1);
        wait_drain();
        check("short_err_set", 64'(err_short), 64'd1);
        check("short_beats", 64'(out_data.size()), 64'd8);
        if (out_data.size() >= 1) begin
            b = out_data[0];
            check("short_zero_rows", 64'(b[63:24]), 64'd0);
        end
        clr_err = 1'b1;
        @(posedge aclk);
        #1;
        clr_err = 1'b0;
        check("short_err_clr", 64'(err_short), 64'd0);

        // Reset after three output beats of a stalled block
        fixed_ready = 0;
        @(posedge aclk);
        #1;
        out_cyc.delete();
        send_block(8, 1, 0, 0);
        fixed_ready = 1;
        repeat (3) @(posedge aclk);
        #1;
        fixed_ready = 0;
        @(posedge aclk);
        #1;
        check("mid_drain_beats", 64'(out_cyc.size()), 64'd3);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_q.delete();
        check("mid_rst_valid", 64'(dest_tvalid), 64'd0);
        check("mid_rst_ready", 64'(src_tready), 64'd1);
        check("mid_rst_blk_cnt", 64'(blk_cnt), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        fixed_ready = 1;
        repeat (5) @(posedge aclk);
        #1;
        check("mid_rst_quiet", 64'(dest_tvalid), 64'd0);

        // Randomized traffic, 100 blocks with occasional short packets
        rnd_ready = 1;
        repeat (100) begin
            n    = ($urandom % 4 == 0) ? int'($urandom_range(1, 7)) : 8;
            last = (n < 8) ? 1'b1 : 1'($urandom % 2);
            send_block(n, last, 2, 0);
        end
        wait_drain();
        rnd_ready = 0;
        repeat (2) @(posedge aclk);
        #1;
        check("rand_blk_cnt", 64'(blk_cnt), 64'd100);
        check("rand_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_transpose8.md
STREAM_TRANSPOSE8 -- requirements
Module: stream_transpose8

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the stream data width; only 64 is supported (8 pixels of 8 bits per beat).
REQ-002 SHALL have parameter DEST_WIDTH, default 3, the stream routing destination width.
REQ-003 SHALL have parameter OUT_DEST, default 0, the constant driven on dest_tdest (0 routes to the output buffer port).
REQ-004 aclk  input  1  clock; all logic rising-edge.
REQ-005 areset  input  1  synchronous, active-high reset.
REQ-006 src_tvalid/src_tready/src_tlast  input/output/input  1 each  AXI-stream slave handshake and packet end (crossbar side).
REQ-007 src_tdata  input  64  one pixel row; byte k = bits [8k+7:8k] is column k.
REQ-008 src_tdest  input  DEST_WIDTH  ignored.
REQ-009 dest_tvalid/dest_tready/dest_tlast  output/input/output  1 each  AXI-stream master handshake and packet end.
REQ-010 dest_tdata  output  64  one transposed row; dest_tdest  output  DEST_WIDTH  = OUT_DEST.
REQ-011 clr_err  input  1  one-cycle pulse that clears err_short.
REQ-012 err_short  output  1  sticky flag: a packet ended mid-block.
REQ-013 blk_cnt  output  16  count of blocks fully emitted, wraps 0xFFFF->0.
REQ-014 busy  output  1  high while either bank is FILLING with at least one row, FULL, or DRAINING.

Function
REQ-015 SHALL transpose 8x8 blocks of bytes: for output beat c of a block, byte r SHALL equal byte c of input beat r.
REQ-016 SHALL use two banks (ping-pong); each bank has states EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
REQ-017 Write side: wr_sel selects the bank; rows are written at wr_row (3 bits), which increments on each src handshake.
REQ-018 src_tready SHALL equal (bank[wr_sel] is EMPTY or FILLING); it is low only when both banks are FULL or DRAINING.
REQ-019 On the handshake with wr_row==7, the bank SHALL become FULL, wr_row SHALL reset to 0, and wr_sel SHALL toggle.
REQ-020 On a handshake with src_tlast=1 and wr_row<7, the remaining rows SHALL be zero-filled, the bank SHALL become FULL, err_short SHALL set, and wr_sel SHALL toggle.
REQ-021 A block's tlast attribute SHALL be set when the handshake that closes it carries src_tlast=1.
REQ-022 Read side: rd_sel selects the bank and rd_col (3 bits) the column; dest_tvalid SHALL be high whenever bank[rd_sel] is FULL or DRAINING.
REQ-023 dest_tvalid SHALL rise the cycle after the closing input handshake (latency 1), and dest_tdata SHALL be driven from bank registers.
REQ-024 dest_tdata, dest_tlast and dest_tvalid SHALL hold stable while dest_tvalid=1 and dest_tready=0.
REQ-025 dest_tlast SHALL be high on rd_col==7 only when the block's tlast attribute is set.
REQ-026 On the handshake with rd_col==7, the bank SHALL become EMPTY, rd_sel SHALL toggle, and blk_cnt SHALL increment.
REQ-027 A bank closing and the other bank finishing its drain in the same cycle SHALL both take effect; with continuous valid/ready, throughput is 1 beat/cycle with no bubbles.
REQ-028 If clr_err and a short-packet event occur in the same cycle, err_short SHALL be 1 (set wins).

Reset
REQ-029 On areset, both banks SHALL become EMPTY; wr_sel, rd_sel, wr_row, rd_col, blk_cnt and err_short SHALL be 0.
REQ-030 During and after reset, dest_tvalid=0, dest_tlast=0 and busy=0; src_tready SHALL be 1 from the first cycle after reset.
REQ-031 Reset mid-block SHALL discard partial and undrained data without emitting further beats.
REQ-032 Bank data registers need no reset; dest_tdata is don't-care while dest_tvalid=0.

Structure
REQ-033 BLK_DIM=8, PIX_W=8 and the bank-state enum SHALL reside in the shared package video_acc_pkg.
REQ-034 A single sub-module, transpose_bank, SHALL implement one 8x8 byte array with a row-write port and a column-read port; it SHALL be instantiated twice.

Verification
REQ-035 Single block: input row r byte c = 8r+c, tlast on row 7 -> output beat 0 = 0x3830282018100800, beat 7 = 0x3F372F271F170F07, dest_tlast only on beat 7, blk_cnt=1.
REQ-036 Streaming: 4 back-to-back blocks with dest_tready=1 -> first dest_tvalid 1 cycle after the 8th input handshake, then 32 consecutive output beats with no gaps.
REQ-037 Backpressure: 3 blocks with dest_tready=0 -> src_tready drops after 16 accepted beats; releasing dest_tready yields 24 beats in order.
REQ-038 Short packet: tlast on row 2 -> 8 output beats with bytes 3..7 zero, dest_tlast on beat 7, err_short=1; a clr_err pulse -> err_short=0.
REQ-039 Reset mid-drain: areset after 3 output beats -> dest_tvalid=0 on the next cycle, src_tready=1, blk_cnt=0, busy=0.
REQ-040 Random valid/ready toggling over 100 blocks -> output matches the reference transpose model and blk_cnt=100.
